pts_tx_ctrl: RTL and testbench
==============================

Name: pts_tx_ctrl

Overview:
- Sequencer and arbiter for the parallel-to-serial shift register on the transmit path.
- Two requesters offer NUM_BITS-wide words over valid/ready handshakes. A round-robin arbiter picks one requester.
- The block then drives the shift register's load and shift strobes. Each bit is held on the serial line for CLKS_PER_BIT cycles.
- Emits busy/done status for upstream flow control.

Parameters:
- NUM_BITS, 8, word width and bits per frame (>=2).
- CLKS_PER_BIT, 4, clock cycles each bit is held before the next shift (>=1).
- GAP_BITS, 1, idle bit periods between frames (used only with the optional feature, >=1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  NUM_BITS  requester 0 word.
- req0_ready  out  1  word 0 accepted this cycle when high with req0_valid.
- req1_valid  in  1  requester 1 has a word.
- req1_data  in  NUM_BITS  requester 1 word.
- req1_ready  out  1  word 1 accepted this cycle when high with req1_valid.
- sr_load_enable  out  1  load strobe to the shift register.
- sr_shift_enable  out  1  shift strobe to the shift register.
- sr_parallel_in  out  NUM_BITS  word presented to the shift register.
- grant_id  out  1  requester owning the current or last frame.
- busy  out  1  high from LOAD through the end of SHIFT (and GAP).
- done  out  1  one-cycle pulse in the final cycle of the last bit.

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. Reset is sampled only on the rising edge of clk.
- Reset values:
  - state=IDLE.
  - All outputs 0: sr_parallel_in=0, grant_id=0.
  - Round-robin pointer set so requester 0 wins the first tie.
  - Bit and timer counters 0.
- States: IDLE, LOAD, SHIFT, GAP (GAP only with the feature).
- IDLE:
  - reqN_ready is combinational. Only one ready is ever high, and only for the requester the arbiter selects.
  - Only one valid: that requester is selected.
  - Both valid: the requester not granted last time is selected.
  - On handshake (valid&ready): latch the data into a holding register, set grant_id, update the pointer, go to LOAD.
  - No valid: stay in IDLE, all strobes 0.
- LOAD (exactly 1 cycle):
  - sr_load_enable=1 and sr_parallel_in=held word.
  - Clear the bit counter and timer, go to SHIFT.
  - Bit 0 appears on the serial line from the cycle after LOAD.
- SHIFT:
  - The timer counts 0..CLKS_PER_BIT-1.
  - At terminal count with bit_cnt<NUM_BITS-1: sr_shift_enable=1 for that cycle, bit_cnt++, timer wraps to 0.
  - At terminal count with bit_cnt==NUM_BITS-1: no shift, done=1, go to IDLE (or GAP).
  - SHIFT lasts exactly NUM_BITS*CLKS_PER_BIT cycles.
  - CLKS_PER_BIT=1: a shift strobe every SHIFT cycle except the last.
- Strobes: sr_load_enable and sr_shift_enable are never high together. Both are 0 outside LOAD and SHIFT.
- Latency: handshake at cycle T gives LOAD at T+1; bit 0 is valid T+2..T+1+CLKS_PER_BIT.
- Back-to-back frames: minimum spacing between done and the next LOAD is 1 IDLE cycle.
- Handshake rules:
  - Requesters hold valid and data stable until ready.
  - reqN_data is ignored when not handshaking.
  - Valid dropping before grant is legal; arbitration is re-evaluated each IDLE cycle.
- Reset mid-frame: immediate return to reset values. No done pulse; the frame is abandoned.
- Widths:
  - bit_cnt is $clog2(NUM_BITS) bits.
  - The timer is max(1,$clog2(CLKS_PER_BIT)) bits and wraps with no overflow beyond terminal.

Optional Feature:
- Macro PTS_CTRL_GAP_EN.
- Defined: after done the FSM enters GAP for GAP_BITS*CLKS_PER_BIT cycles. In GAP, both readys are 0, busy=1 and strobes are 0; then it goes to IDLE.
- Undefined: the GAP state and its counter are not compiled; SHIFT goes directly to IDLE and GAP_BITS is ignored.

Decomposition:
- Package pts_ctrl_pkg:
  - State enum typedef (IDLE, LOAD, SHIFT, GAP).
  - Grant-id typedef.
  - Localparam helpers for counter widths.
- Sub-module pts_bit_timer: a modulo-CLKS_PER_BIT counter with synchronous clear, enable, and a terminal-count output. It is reused for the GAP count.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no valids. Expect all outputs 0 and readys 0 for 10 cycles.
- Single word (NUM_BITS=8, CLKS_PER_BIT=4), req0 sends 8'hA5 at T:
  - Expect req0_ready=1 at T and sr_load_enable=1 with sr_parallel_in=8'hA5 at T+1.
  - Expect 7 shift pulses at T+5,T+9,...,T+29, and done at T+33.
- Contention: both valid with 8'h11 (req0) and 8'h22 (req1).
  - Expect req0 served first (grant_id=0), then req1 (grant_id=1) with load at done+2.
  - A third back-to-back req0 word is served after req1.
- CLKS_PER_BIT=1: one word. Expect shift asserted 7 consecutive cycles after LOAD and done on the 8th SHIFT cycle.
- Reset mid-frame: assert rst during the 3rd bit. Next cycle expect IDLE, strobes 0, no done; a new req1 word is then accepted normally.
- With PTS_CTRL_GAP_EN and GAP_BITS=2, CLKS_PER_BIT=4: two queued words. Expect readys 0 for 8 cycles after done, then a handshake on the next cycle.

Source files
------------

// File: rtl/pts_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pts_ctrl_pkg
//   Shared types and helpers for the parallel-to-serial transmit controller.
//
//   Contents:
//     state_e      - controller state encoding (IDLE, LOAD, SHIFT, GAP)
//     ST_*         - plain logic constants carrying the same encoding, for
//                    code that keeps its state register as raw logic
//     grant_t      - requester identifier (0 or 1)
//     GRANT_REQ*   - named grant values
//     cnt_width()  - counter width for a modulo-N counter, never below 1 bit
//
//   Optional feature macro (consumed by pts_tx_ctrl): PTS_CTRL_GAP_EN
// ---------------------------------------------------------------------------
package pts_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_e;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_LOAD  = LOAD;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_GAP   = GAP;

  typedef logic grant_t;

  localparam grant_t GRANT_REQ0 = 1'b0;
  localparam grant_t GRANT_REQ1 = 1'b1;

  // Width of a counter that must represent 0..modulus-1. A modulus of 1 or 2
  // still gets one bit so the counter register always exists.
  function automatic int cnt_width(input int modulus);
    return (modulus <= 2) ? 1 : $clog2(modulus);
  endfunction

endpackage : pts_ctrl_pkg

// File: rtl/pts_bit_timer.sv
// ---------------------------------------------------------------------------
// pts_bit_timer
//   Modulo-MODULUS cycle counter. Counts 0..MODULUS-1 while enabled and wraps
//   back to 0 after the terminal value; never runs past the terminal count.
//   Used for the per-bit hold time and, when enabled, the inter-frame gap.
//
//   Parameters:
//     MODULUS  number of cycles per period (>=1)
//
//   Ports:
//     clk  in   system clock, rising edge
//     rst  in   synchronous active-high reset, clears the count
//     clr  in   synchronous clear, takes priority over en
//     en   in   advance the count this cycle
//     tc   out  count is at MODULUS-1 (terminal count), unqualified by en
// ---------------------------------------------------------------------------
module pts_bit_timer
  import pts_ctrl_pkg::*;
#(
  parameter int MODULUS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int             CNT_W = cnt_width(MODULUS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MODULUS - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CNT_W'(1);
    end
  end

  // With MODULUS=1 the count is pinned at 0, so tc is permanently high.
  assign tc = (cnt == LAST);

endmodule : pts_bit_timer

// File: rtl/pts_tx_ctrl.sv
// ---------------------------------------------------------------------------
// pts_tx_ctrl
//   Sequencer and two-way round-robin arbiter in front of a parallel-to-serial
//   shift register. A granted word is loaded in one LOAD cycle, then SHIFT
//   holds each bit for CLKS_PER_BIT cycles, pulsing the shift strobe between
//   bits and raising done in the final cycle of the last bit.
//
//   Optional feature: define PTS_CTRL_GAP_EN to insert GAP_BITS*CLKS_PER_BIT
//   idle cycles (GAP state, busy high, readys low) after every frame. Without
//   the macro the GAP state and its timer are not built and GAP_BITS is only
//   range-checked.
//
//   Parameters:
//     NUM_BITS      word width / bits per frame (>=2)
//     CLKS_PER_BIT  cycles each bit is held (>=1)
//     GAP_BITS      idle bit periods between frames (>=1, feature only)
//
//   Ports:
//     clk              in   system clock, rising edge
//     rst              in   synchronous active-high reset
//     req0_valid       in   requester 0 offers a word
//     req0_data        in   requester 0 word
//     req0_ready       out  requester 0 accepted (combinational, IDLE only)
//     req1_valid       in   requester 1 offers a word
//     req1_data        in   requester 1 word
//     req1_ready       out  requester 1 accepted (combinational, IDLE only)
//     sr_load_enable   out  shift register parallel load strobe
//     sr_shift_enable  out  shift register shift strobe
//     sr_parallel_in   out  word presented to the shift register
//     grant_id         out  requester owning the current or last frame
//     busy             out  high in LOAD, SHIFT and GAP
//     done             out  one-cycle pulse in the last cycle of the last bit
// ---------------------------------------------------------------------------
module pts_tx_ctrl
  import pts_ctrl_pkg::*;
#(
  parameter int NUM_BITS     = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int GAP_BITS     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  input  logic [NUM_BITS-1:0] req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [NUM_BITS-1:0] req1_data,
  output logic                req1_ready,
  output logic                sr_load_enable,
  output logic                sr_shift_enable,
  output logic [NUM_BITS-1:0] sr_parallel_in,
  output logic                grant_id,
  output logic                busy,
  output logic                done
);

  localparam int               BIT_W    = cnt_width(NUM_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NUM_BITS - 1);

  if (NUM_BITS < 2 || CLKS_PER_BIT < 1 || GAP_BITS < 1) begin : g_bad_params
    $error("pts_tx_ctrl: NUM_BITS>=2, CLKS_PER_BIT>=1, GAP_BITS>=1 required");
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic [1:0]          state;
  logic [1:0]          state_nxt;
  grant_t              last_grant;   // round-robin pointer
  grant_t              grant_q;
  logic [NUM_BITS-1:0] hold_q;
  logic [BIT_W-1:0]    bit_cnt;

  // -------------------------------------------------------------------------
  // Decoded conditions
  // -------------------------------------------------------------------------
  logic is_idle;
  logic is_load;
  logic is_shift;
  logic bit_tc;
  logic sel0;
  logic sel1;
  logic accept;
  logic shift_step;
  logic frame_end;

  assign is_idle  = (state == ST_IDLE);
  assign is_load  = (state == ST_LOAD);
  assign is_shift = (state == ST_SHIFT);

  // -------------------------------------------------------------------------
  // Round-robin arbiter: a lone requester always wins; on a tie the
  // requester that was not granted last time wins. Reset points the pointer
  // at requester 1 so requester 0 wins the first tie.
  // -------------------------------------------------------------------------
  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    sel0 = req0_valid;
    sel1 = req1_valid;
    if (req0_valid && req1_valid) begin
      sel0 = (last_grant == GRANT_REQ1);
      sel1 = (last_grant == GRANT_REQ0);
    end
  end

  assign req0_ready = is_idle && sel0;
  assign req1_ready = is_idle && sel1;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // -------------------------------------------------------------------------
  // Bit timing. The timer is cleared in LOAD so bit 0 gets a full period
  // starting with the first SHIFT cycle.
  // -------------------------------------------------------------------------
  pts_bit_timer #(
    .MODULUS (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk (clk),
    .rst (rst),
    .clr (is_load),
    .en  (is_shift),
    .tc  (bit_tc)
  );

  assign shift_step = is_shift && bit_tc && (bit_cnt != LAST_BIT);
  assign frame_end  = is_shift && bit_tc && (bit_cnt == LAST_BIT);

  // -------------------------------------------------------------------------
  // Optional inter-frame gap
  // -------------------------------------------------------------------------
`ifdef PTS_CTRL_GAP_EN
  localparam logic [1:0] ST_AFTER_FRAME = ST_GAP;

  logic is_gap;
  logic not_gap;
  logic gap_tc;

  assign is_gap  = (state == ST_GAP);
  assign not_gap = !is_gap;

  // Held in clear outside GAP so every gap starts from zero.
  pts_bit_timer #(
    .MODULUS (GAP_BITS * CLKS_PER_BIT)
  ) u_gap_timer (
    .clk (clk),
    .rst (rst),
    .clr (not_gap),
    .en  (is_gap),
    .tc  (gap_tc)
  );
`else
  localparam logic [1:0] ST_AFTER_FRAME = ST_IDLE;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)    state_nxt = ST_LOAD;
      ST_LOAD:                 state_nxt = ST_SHIFT;
      ST_SHIFT: if (frame_end) state_nxt = ST_AFTER_FRAME;
`ifdef PTS_CTRL_GAP_EN
      ST_GAP:   if (gap_tc)    state_nxt = ST_IDLE;
`endif
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the holding register is reset as well because it drives
      // sr_parallel_in directly and that output must read 0 out of reset.
      state      <= ST_IDLE;
      last_grant <= GRANT_REQ1;
      grant_q    <= GRANT_REQ0;
      hold_q     <= '0;
      bit_cnt    <= '0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        hold_q     <= req1_ready ? req1_data : req0_data;
        grant_q    <= req1_ready ? GRANT_REQ1 : GRANT_REQ0;
        last_grant <= req1_ready ? GRANT_REQ1 : GRANT_REQ0;
      end

      if (is_load) begin
        bit_cnt <= '0;
      end else if (shift_step) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign sr_load_enable  = is_load;
  assign sr_shift_enable = shift_step;
  assign sr_parallel_in  = hold_q;
  assign grant_id        = grant_q;
  assign busy            = !is_idle;
  assign done            = frame_end;

endmodule : pts_tx_ctrl

// File: tb/tb_pts_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pts_tx_ctrl
//   Two controller instances (CLKS_PER_BIT=4 and CLKS_PER_BIT=1) run against
//   a frame-position model: each frame is described only by how many cycles
//   have passed since its handshake, from which load/shift/done/busy follow
//   by arithmetic. Directed sequences with literal timing expectations come
//   first, then randomized requester traffic with occasional resets.
// ---------------------------------------------------------------------------
module tb_pts_tx_ctrl;

  localparam int N        = 8;
  localparam int GAP_BITS = 2;

  logic       clk = 1'b0;
  logic       rst  [2];
  logic       v0   [2];
  logic       v1   [2];
  logic [7:0] d0   [2];
  logic [7:0] d1   [2];
  logic       rdy0 [2];
  logic       rdy1 [2];
  logic       ld   [2];
  logic       sh   [2];
  logic [7:0] par  [2];
  logic       gid  [2];
  logic       bsy  [2];
  logic       dn   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pts_tx_ctrl #(.NUM_BITS(N), .CLKS_PER_BIT(4), .GAP_BITS(GAP_BITS)) u_dut0 (
    .clk             (clk),
    .rst             (rst[0]),
    .req0_valid      (v0[0]),
    .req0_data       (d0[0]),
    .req0_ready      (rdy0[0]),
    .req1_valid      (v1[0]),
    .req1_data       (d1[0]),
    .req1_ready      (rdy1[0]),
    .sr_load_enable  (ld[0]),
    .sr_shift_enable (sh[0]),
    .sr_parallel_in  (par[0]),
    .grant_id        (gid[0]),
    .busy            (bsy[0]),
    .done            (dn[0])
  );

  pts_tx_ctrl #(.NUM_BITS(N), .CLKS_PER_BIT(1), .GAP_BITS(GAP_BITS)) u_dut1 (
    .clk             (clk),
    .rst             (rst[1]),
    .req0_valid      (v0[1]),
    .req0_data       (d0[1]),
    .req0_ready      (rdy0[1]),
    .req1_valid      (v1[1]),
    .req1_data       (d1[1]),
    .req1_ready      (rdy1[1]),
    .sr_load_enable  (ld[1]),
    .sr_shift_enable (sh[1]),
    .sr_parallel_in  (par[1]),
    .grant_id        (gid[1]),
    .busy            (bsy[1]),
    .done            (dn[1])
  );

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic string nm(input string s, input int i);
    return $sformatf("%s[%0d]", s, i);
  endfunction

  function automatic int clks(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int gapc(input int i);
`ifdef PTS_CTRL_GAP_EN
    return GAP_BITS * clks(i);
`else
    return (i < 0) ? 1 : 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Reference model: position within the current frame (-1 = idle).
  // Position 0 is LOAD, 1..N*C is SHIFT, then the gap cycles.
  // -------------------------------------------------------------------------
  int         mpos   [2];
  logic       mlast  [2];
  logic [7:0] mheld  [2];
  logic       mgid   [2];
  bit         mvalid [2] = '{0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int   c;
      int   p;
      logic idle;
      logic er0;
      logic er1;
      c    = clks(i);
      p    = mpos[i];
      idle = (p < 0);
      er0  = idle && v0[i] && (!v1[i] || mlast[i]);
      er1  = idle && v1[i] && (!v0[i] || !mlast[i]);
      if (mvalid[i]) begin
        check(nm("ready0", i), rdy0[i], er0);
        check(nm("ready1", i), rdy1[i], er1);
        check(nm("load", i),   ld[i],   p == 0);
        check(nm("shift", i),  sh[i],   (p >= 1) && (p < N * c) && (p % c == 0));
        check(nm("done", i),   dn[i],   p == N * c);
        check(nm("busy", i),   bsy[i],  !idle);
        check(nm("par", i),    par[i],  mheld[i]);
        check(nm("grant", i),  gid[i],  mgid[i]);
      end
      if (rst[i]) begin
        mpos[i]   = -1;
        mlast[i]  = 1'b1;
        mheld[i]  = '0;
        mgid[i]   = 1'b0;
        mvalid[i] = 1;
      end else if (mvalid[i]) begin
        if (idle) begin
          if (er0) begin
            mpos[i] = 0; mheld[i] = d0[i]; mgid[i] = 1'b0; mlast[i] = 1'b0;
          end else if (er1) begin
            mpos[i] = 0; mheld[i] = d1[i]; mgid[i] = 1'b1; mlast[i] = 1'b1;
          end
        end else if (p >= N * c + gapc(i)) begin
          mpos[i] = -1;
        end else begin
          mpos[i] = p + 1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Directed building blocks (literal expectations)
  // -------------------------------------------------------------------------
  task automatic wait_idle(input int inst);
    bit ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (bsy[inst] === 1'b0) ok = 1;
    end
    check(nm("idle_seen", inst), ok, 1);
  endtask

  task automatic wait_done(input int inst);
    bit seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (dn[inst] === 1'b1) seen = 1;
    end
    check(nm("done_seen", inst), seen, 1);
  endtask

  // Offsets are relative to the handshake cycle T.
  task automatic single_word(input int inst, input int rq, input logic [7:0] w,
                             input int first_e, input int last_e, input int done_e);
    int first_s = -1;
    int last_s  = -1;
    int n_s     = 0;
    int done_at = -1;
    wait_idle(inst);
    tick();
    if (rq == 0) begin v0[inst] = 1'b1; d0[inst] = w; end
    else         begin v1[inst] = 1'b1; d1[inst] = w; end
    @(negedge clk);
    check(nm("sw_ready", inst), (rq == 0) ? rdy0[inst] : rdy1[inst], 1);
    tick();
    v0[inst] = 1'b0;
    v1[inst] = 1'b0;
    @(negedge clk);
    check(nm("sw_load", inst),  ld[inst],  1);
    check(nm("sw_par", inst),   par[inst], w);
    check(nm("sw_grant", inst), gid[inst], rq);
    for (int k = 2; k <= done_e + 2; k++) begin
      @(negedge clk);
      if (sh[inst] === 1'b1) begin
        if (first_s < 0) first_s = k;
        last_s = k;
        n_s++;
      end
      if (dn[inst] === 1'b1 && done_at < 0) done_at = k;
    end
    check(nm("sw_first_shift", inst), first_s, first_e);
    check(nm("sw_last_shift", inst),  last_s,  last_e);
    check(nm("sw_shift_count", inst), n_s,     N - 1);
    check(nm("sw_done_at", inst),     done_at, done_e);
  endtask

  task automatic drive_req(input logic hs, inout logic v, inout logic [7:0] d);
    if (hs) begin
      if ($urandom_range(0, 1) == 1) d = 8'($urandom);
      else begin v = 1'b0; d = 8'($urandom); end
    end else if (v) begin
      if ($urandom_range(0, 15) == 0) begin v = 1'b0; d = 8'($urandom); end
    end else begin
      d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) v = 1'b1;
    end
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    int g;
    int dn_cnt;
    logic hs [2][2];
    g = gapc(0);
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; v0[i] = 1'b0; v1[i] = 1'b0; d0[i] = '0; d1[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Reset then idle
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle_ctrl", {rdy0[0], rdy1[0], ld[0], sh[0], dn[0], bsy[0], gid[0]}, 0);
      check("idle_par", par[0], 0);
    end

    // Single word, CLKS_PER_BIT=4 and CLKS_PER_BIT=1
    single_word(0, 0, 8'hA5, 5, 29, 33);
    single_word(1, 0, 8'h96, 2, 8, 9);
    single_word(1, 1, 8'h69, 2, 8, 9);

    // Contention after a fresh reset: req0 wins the first tie
    wait_idle(0);
    tick(); rst[0] = 1'b1;
    tick(); rst[0] = 1'b0;
    tick();
    v0[0] = 1'b1; d0[0] = 8'h11;
    v1[0] = 1'b1; d1[0] = 8'h22;
    @(negedge clk);
    check("ct_ready0", rdy0[0], 1);
    check("ct_ready1", rdy1[0], 0);
    tick();
    d0[0] = 8'h33;                  // third word queued back-to-back
    @(negedge clk);
    check("ct_load0", ld[0], 1);
    check("ct_par0",  par[0], 8'h11);
    check("ct_gid0",  gid[0], 0);
    wait_done(0);
    for (int k = 0; k < g; k++) begin
      @(negedge clk);
      check("ct_gap_ready", {rdy0[0], rdy1[0]}, 0);
    end
    @(negedge clk);
    check("ct_ready1_b", rdy1[0], 1);
    check("ct_ready0_b", rdy0[0], 0);
    tick();
    v1[0] = 1'b0;
    @(negedge clk);
    check("ct_load1", ld[0], 1);
    check("ct_par1",  par[0], 8'h22);
    check("ct_gid1",  gid[0], 1);
    wait_done(0);
    repeat (g) @(negedge clk);
    @(negedge clk);
    check("ct_ready0_c", rdy0[0], 1);
    tick();
    v0[0] = 1'b0;
    @(negedge clk);
    check("ct_load2", ld[0], 1);
    check("ct_par2",  par[0], 8'h33);
    check("ct_gid2",  gid[0], 0);
    wait_done(0);

    // Reset in the middle of bit 2
    wait_idle(0);
    tick();
    v0[0] = 1'b1; d0[0] = 8'h5A;
    @(negedge clk);
    check("rm_ready", rdy0[0], 1);
    tick();
    v0[0] = 1'b0;
    @(negedge clk);
    check("rm_load", ld[0], 1);
    repeat (10) @(negedge clk);
    tick();
    rst[0] = 1'b1;
    @(negedge clk);
    check("rm_busy_before", bsy[0], 1);
    tick();
    rst[0] = 1'b0;
    @(negedge clk);
    check("rm_after_ctrl", {bsy[0], ld[0], sh[0], dn[0], gid[0]}, 0);
    check("rm_after_par", par[0], 0);
    dn_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dn[0] !== 1'b0) dn_cnt++;
    end
    check("rm_no_done", dn_cnt, 0);
    single_word(0, 1, 8'hC3, 5, 29, 33);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        hs[i][0] = v0[i] && rdy0[i];
        hs[i][1] = v1[i] && rdy1[i];
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        rst[i] = ($urandom_range(0, 499) == 0);
        drive_req(hs[i][0], v0[i], d0[i]);
        drive_req(hs[i][1], v1[i], d1[i]);
      end
    end

    // Drain
    tick();
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; v0[i] = 1'b0; v1[i] = 1'b0;
    end
    repeat (80) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pts_tx_ctrl
